// File: rtl/ysyx_24100027_pkg.sv
// Shared definitions for the NPC execution sequencer: FSM states, halt causes, reset PC.
package ysyx_24100027_pkg;

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_IWAIT  = 3'd2,
        S_DECODE = 3'd3,
        S_DREQ   = 3'd4,
        S_DWAIT  = 3'd5,
        S_WB     = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [1:0] ERR_EBREAK  = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // States in which the core is waiting on a bus and the timeout counter runs.
    function automatic logic is_bus_wait(input state_t s);
        return s inside {S_FETCH, S_IWAIT, S_DREQ, S_DWAIT};
    endfunction

endpackage

// File: rtl/ysyx_24100027_bus_timer.sv
// Saturating bus-wait counter: cleared on request, counts while enabled, flags all-ones.
module ysyx_24100027_bus_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = &r_count;

endmodule

// File: rtl/ysyx_24100027_exec_sequencer.sv
// Multi-cycle NPC control FSM: fetch, decode, optional data access, writeback.
// Owns PC and the latched instruction; halts on ebreak, illegal op or bus timeout.
module ysyx_24100027_exec_sequencer
    import ysyx_24100027_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    input  logic [31:0] next_pc,
    input  logic        dec_regwr,
    input  logic        dec_load,
    input  logic        dec_store,
    input  logic        dec_trap,
    input  logic        dec_illegal,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        dmem_rvalid,
    output logic        rf_we,
    output logic        commit,
    output logic        halted,
    output logic [1:0]  err
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [1:0]  r_err;

    logic        w_expired;
    logic        w_timer_clr;
    logic        w_timer_en;
    logic        w_inst_load;
    logic        w_err_set;
    logic [1:0]  w_err_code;

    ysyx_24100027_bus_timer #(
        .WIDTH(TIMEOUT_W)
    ) u_bus_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_timer_clr),
        .i_enable (w_timer_en),
        .o_expired(w_expired)
    );

    assign w_timer_clr = (w_next != r_state);
    assign w_timer_en  = is_bus_wait(r_state);

    always_comb begin
        w_next      = r_state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        commit      = 1'b0;
        w_inst_load = 1'b0;
        w_err_set   = 1'b0;
        w_err_code  = ERR_EBREAK;

        case (r_state)
            S_RST: begin
                w_next = S_FETCH;
            end

            // Timeout takes priority in every wait state: the request is
            // dropped in the expiring cycle so no late ack can be accepted.
            S_FETCH: begin
                if (w_expired) begin
                    w_next     = S_HALT;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end else begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        if (imem_rvalid) begin
                            w_inst_load = 1'b1;
                            w_next      = S_DECODE;
                        end else begin
                            w_next = S_IWAIT;
                        end
                    end
                end
            end

            S_IWAIT: begin
                if (w_expired) begin
                    w_next     = S_HALT;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end else if (imem_rvalid) begin
                    w_inst_load = 1'b1;
                    w_next      = S_DECODE;
                end
            end

            S_DECODE: begin
                if (dec_illegal) begin
                    w_next     = S_HALT;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_ILLEGAL;
                end else if (dec_trap) begin
                    commit     = 1'b1;
                    w_next     = S_HALT;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_EBREAK;
                end else if (dec_load || dec_store) begin
                    w_next = S_DREQ;
                end else begin
                    w_next = S_WB;
                end
            end

            S_DREQ: begin
                if (w_expired) begin
                    w_next     = S_HALT;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end else begin
                    dmem_req = 1'b1;
                    dmem_we  = dec_store;
                    if (dmem_ack) begin
                        if (dec_store || dmem_rvalid) begin
                            w_next = S_WB;
                        end else begin
                            w_next = S_DWAIT;
                        end
                    end
                end
            end

            S_DWAIT: begin
                if (w_expired) begin
                    w_next     = S_HALT;
                    w_err_set  = 1'b1;
                    w_err_code = ERR_TIMEOUT;
                end else if (dmem_rvalid) begin
                    w_next = S_WB;
                end
            end

            S_WB: begin
                rf_we  = dec_regwr && !dec_store;
                commit = 1'b1;
                w_next = S_FETCH;
            end

            S_HALT: begin
                w_next = S_HALT;
            end

            default: begin
                w_next = S_RST;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RST;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
            r_err   <= ERR_EBREAK;
        end else begin
            r_state <= w_next;
            if (r_state == S_WB) begin
                r_pc <= next_pc;
            end
            if (w_inst_load) begin
                r_inst <= imem_rdata;
            end
            if (w_err_set) begin
                r_err <= w_err_code;
            end
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign halted    = (r_state == S_HALT);
    assign err       = r_err;

endmodule

// File: tb/tb_ysyx_24100027_exec_sequencer.sv
// Randomized bench for the exec sequencer: a bus responder with chosen latencies and a
// per-instruction model predicting cycle count, handshake lengths, strobes and PC flow.
module tb_ysyx_24100027_exec_sequencer;

    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        dec_regwr;
    logic        dec_load;
    logic        dec_store;
    logic        dec_trap;
    logic        dec_illegal;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        dmem_rvalid;
    logic        rf_we;
    logic        commit;
    logic        halted;
    logic [1:0]  err;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    ysyx_24100027_exec_sequencer #(
        .RESET_PC (RPC),
        .TIMEOUT_W(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .pc         (pc),
        .next_pc    (next_pc),
        .dec_regwr  (dec_regwr),
        .dec_load   (dec_load),
        .dec_store  (dec_store),
        .dec_trap   (dec_trap),
        .dec_illegal(dec_illegal),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .dmem_rvalid(dmem_rvalid),
        .rf_we      (rf_we),
        .commit     (commit),
        .halted     (halted),
        .err        (err)
    );

    task automatic clear_inputs;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        dmem_ack    = 1'b0;
        dmem_rvalid = 1'b0;
        dec_regwr   = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_trap    = 1'b0;
        dec_illegal = 1'b0;
        next_pc     = '0;
    endtask

    // Leaves the DUT in its first FETCH cycle, 1 time unit after the edge.
    task automatic reset_dut;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        m_pc = RPC;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store. a = cycles before imem_ack, r = cycles from ack to
    // rvalid, da = cycles before dmem_ack, dr = cycles from dmem_ack to load data.
    task automatic run_instr(input logic [31:0] instr, input int kind, input int a, input int r,
                             input int da, input int dr, input logic regwr,
                             input logic [31:0] npc, input string name);
        int cyc = 0, ireq = 0, ireq_resp = 0, dreq = 0, dcnt = 0, since = 0, dsince = 0;
        int rfw = 0, bad_addr = 0, bad_we = 0, bad_pc = 0, commit_cyc = -1, exp_lat, exp_rfw;
        bit acked = 0, fetched = 0, dacked = 0, drv = 0, done = 0;
        logic rfw_at_commit = 1'b0;

        exp_lat = a + r + 3 + ((kind != 0) ? (da + 1 + ((kind == 1) ? dr : 0)) : 0);
        exp_rfw = (regwr && kind != 2) ? 1 : 0;
        dec_regwr   = regwr;
        dec_load    = (kind == 1);
        dec_store   = (kind == 2);
        dec_trap    = 1'b0;
        dec_illegal = 1'b0;
        next_pc     = npc;

        while (!done && cyc < 100) begin
            @(negedge clk);
            imem_ack    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            dmem_ack    = 1'b0;
            dmem_rvalid = 1'b0;
            if (!acked) begin
                if (imem_req) begin
                    if (ireq_resp == a) begin
                        imem_ack = 1'b1;
                        acked    = 1;
                        if (r == 0) begin
                            imem_rvalid = 1'b1;
                            imem_rdata  = instr;
                            fetched     = 1;
                        end
                    end
                    ireq_resp++;
                end
            end else if (!fetched) begin
                since++;
                if (since == r) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = instr;
                    fetched     = 1;
                end
            end
            if (dmem_req && !dacked) begin
                if (dcnt == da) begin
                    dmem_ack = 1'b1;
                    dacked   = 1;
                    if (kind == 1 && dr == 0) begin
                        dmem_rvalid = 1'b1;
                        drv         = 1;
                    end
                end
                dcnt++;
            end else if (dacked && !drv && kind == 1) begin
                dsince++;
                if (dsince == dr) begin
                    dmem_rvalid = 1'b1;
                    drv         = 1;
                end
            end
            #1;
            cyc++;
            if (imem_req) begin
                ireq++;
                if (imem_addr !== m_pc) bad_addr++;
            end
            if (dmem_req) begin
                dreq++;
                if (dmem_we !== (kind == 2)) bad_we++;
            end
            if (rf_we === 1'b1) rfw++;
            if (pc !== m_pc) bad_pc++;
            if (commit === 1'b1) begin
                done          = 1;
                commit_cyc    = cyc;
                rfw_at_commit = rf_we;
            end
        end
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        dmem_ack    = 1'b0;
        dmem_rvalid = 1'b0;
        @(posedge clk);
        #1;

        vecs++;
        if (commit_cyc != exp_lat) begin
            errs++;
            $display("FAIL %s latency: got %0d expected %0d", name, commit_cyc, exp_lat);
        end
        vecs++;
        if (ireq != a + 1) begin
            errs++;
            $display("FAIL %s imem_req cycles: got %0d expected %0d", name, ireq, a + 1);
        end
        vecs++;
        if (dreq != ((kind != 0) ? da + 1 : 0)) begin
            errs++;
            $display("FAIL %s dmem_req cycles: got %0d expected %0d", name, dreq,
                     (kind != 0) ? da + 1 : 0);
        end
        vecs++;
        if (rfw != exp_rfw || (exp_rfw == 1 && rfw_at_commit !== 1'b1)) begin
            errs++;
            $display("FAIL %s rf_we pulses: got %0d expected %0d", name, rfw, exp_rfw);
        end
        vecs++;
        if (bad_addr + bad_we + bad_pc != 0) begin
            errs++;
            $display("FAIL %s addr/we/pc stability: got %0d/%0d/%0d bad cycles expected 0",
                     name, bad_addr, bad_we, bad_pc);
        end
        vecs++;
        if (pc !== npc || inst !== instr || commit !== 1'b0) begin
            errs++;
            $display("FAIL %s after WB: pc %h inst %h commit %b expected %h %h 0",
                     name, pc, inst, commit, npc, instr);
        end
        m_pc = npc;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear_inputs();
        imem_ack    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hdead_beef;
        dec_regwr   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (pc !== RPC || inst !== 32'h0) begin
            errs++;
            $display("FAIL reset pc/inst: got %h/%h expected %h/0", pc, inst, RPC);
        end
        vecs++;
        if ({imem_req, dmem_req, dmem_we, rf_we, commit, halted, err} !== 7'b0) begin
            errs++;
            $display("FAIL reset strobes: got %b expected 0",
                     {imem_req, dmem_req, dmem_we, rf_we, commit, halted, err});
        end
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (imem_req !== 1'b0 || commit !== 1'b0) begin
            errs++;
            $display("FAIL rst-state outputs: req %b commit %b expected 0 0", imem_req, commit);
        end
        @(posedge clk);
        #1;
        vecs++;
        if (imem_req !== 1'b1 || imem_addr !== RPC) begin
            errs++;
            $display("FAIL first fetch: req %b addr %h expected 1 %h", imem_req, imem_addr, RPC);
        end
        m_pc = RPC;
    endtask

    task automatic test_addi;
        reset_dut();
        run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 1'b1, RPC + 32'd4, "addi");
    endtask

    task automatic test_fetch_wait;
        run_instr(32'h0010_0113, 0, 1, 3, 0, 0, 1'b1, m_pc + 32'd4, "fetch_wait");
    endtask

    task automatic test_store;
        run_instr(32'h0020_a023, 2, 0, 0, 2, 0, 1'b1, m_pc + 32'd4, "sw");
    endtask

    task automatic test_load;
        run_instr(32'h0000_a183, 1, 0, 0, 0, 2, 1'b1, m_pc + 32'd4, "lw");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            run_instr($urandom, 0, 0, 0, 0, 0, 1'b1, m_pc + 32'd4, "b2b");
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            int          kind;
            logic [31:0] npc;
            kind = $urandom_range(0, 2);
            npc  = ($urandom_range(0, 3) == 0) ? $urandom : m_pc + 32'd4;
            run_instr($urandom, kind, $urandom_range(0, 4), $urandom_range(0, 4),
                      $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)),
                      npc, "random");
        end
    endtask

    task automatic test_halt;
        for (int c = 0; c < 2; c++) begin
            logic [31:0] word;
            int          bad = 0;
            reset_dut();
            word        = (c == 0) ? 32'h0010_0073 : $urandom;
            dec_trap    = 1'b1;
            dec_illegal = (c == 1);
            @(negedge clk);
            imem_ack    = 1'b1;
            imem_rvalid = 1'b1;
            imem_rdata  = word;
            @(negedge clk);
            imem_ack    = 1'b0;
            imem_rvalid = 1'b0;
            #1;
            vecs++;
            if (commit !== (c == 0)) begin
                errs++;
                $display("FAIL halt%0d decode commit: got %b expected %b", c, commit, c == 0);
            end
            @(posedge clk);
            #1;
            vecs++;
            if (halted !== 1'b1 || err !== ((c == 0) ? 2'b00 : 2'b01)) begin
                errs++;
                $display("FAIL halt%0d cause: halted %b err %b expected 1 %b", c, halted, err,
                         (c == 0) ? 2'b00 : 2'b01);
            end
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                imem_ack = 1'b1;
                dmem_ack = 1'b1;
                #1;
                if (imem_req || dmem_req || commit || rf_we || !halted) bad++;
            end
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            vecs++;
            if (bad != 0 || pc !== RPC || inst !== word) begin
                errs++;
                $display("FAIL halt%0d stays halted: bad %0d pc %h inst %h expected 0 %h %h",
                         c, bad, pc, inst, RPC, word);
            end
        end
    endtask

    task automatic test_timeout;
        int reqs = 0;
        int cyc  = 0;
        reset_dut();
        while (halted !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            #1;
            cyc++;
            if (imem_req === 1'b1) reqs++;
        end
        vecs++;
        if (reqs != 15) begin
            errs++;
            $display("FAIL timeout fetch cycles: got %0d expected 15", reqs);
        end
        vecs++;
        if (halted !== 1'b1 || err !== 2'b10) begin
            errs++;
            $display("FAIL timeout cause: halted %b err %b expected 1 10", halted, err);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (halted !== 1'b0 || err !== 2'b00 || pc !== RPC) begin
            errs++;
            $display("FAIL timeout reset: halted %b err %b pc %h expected 0 00 %h",
                     halted, err, pc, RPC);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_pc = RPC;
        run_instr(32'h0050_0093, 0, 0, 0, 0, 0, 1'b1, RPC + 32'd8, "restart");
    endtask

    task automatic test_reset_mid;
        reset_dut();
        dec_store = 1'b1;
        @(negedge clk);
        imem_ack    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0020_a023;
        @(posedge clk);
        #1;
        imem_ack    = 1'b0;
        imem_rvalid = 1'b0;
        @(posedge clk);
        #1;
        vecs++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
            errs++;
            $display("FAIL mid dreq: req %b we %b expected 1 1", dmem_req, dmem_we);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        vecs++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || imem_req !== 1'b0 || inst !== 32'h0) begin
            errs++;
            $display("FAIL mid reset: dreq %b we %b ireq %b inst %h expected 0 0 0 0",
                     dmem_req, dmem_we, imem_req, inst);
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        m_pc = RPC;
        test_reset();
        test_addi();
        test_fetch_wait();
        test_store();
        test_load();
        test_back_to_back();
        test_random();
        test_halt();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
